// File: rtl/cmsdk_ahb_bm_decode_param.sv
// AHB bus-matrix input-port decoder: base/mask region decode, data-phase response mux and an
// internal ERROR default slave. Define AHB_BM_DECODE_ERRCNT_EN to build the decode-error counter.
module cmsdk_ahb_bm_decode_param #(
    parameter int NUM_MI = 3,
    parameter logic [NUM_MI*22-1:0] REGION_BASE =
        (NUM_MI*22)'({{5{22'h3FFFFF}}, 22'h200000, 22'h100000, 22'h000000}),
    parameter logic [NUM_MI*22-1:0] REGION_MASK =
        (NUM_MI*22)'({{5{22'h000000}}, 22'h300000, 22'h300000, 22'h300000}),
    parameter int USER_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HREADYS,
    input  logic                     sel_dec,
    input  logic [21:0]              decode_addr_dec,
    input  logic [1:0]               trans_dec,
    input  logic [NUM_MI-1:0]        active_in,
    input  logic [NUM_MI-1:0]        readyout_in,
    input  logic [2*NUM_MI-1:0]      resp_in,
    input  logic [32*NUM_MI-1:0]     rdata_in,
    input  logic [USER_W*NUM_MI-1:0] ruser_in,
    input  logic                     cnt_clr,
    output logic [NUM_MI-1:0]        sel_out,
    output logic                     active_dec,
    output logic                     HREADYOUTS,
    output logic [1:0]               HRESPS,
    output logic [31:0]              HRDATAS,
    output logic [USER_W-1:0]        HRUSERS,
    output logic [CNT_W-1:0]         err_cnt
);

    localparam int PW = $clog2(NUM_MI + 1);
    localparam logic [PW-1:0] DS_PORT = PW'(NUM_MI);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    ds_state_t       r_state;
    ds_state_t       w_state_nxt;
    logic [PW-1:0]   r_data_port;
    logic [PW-1:0]   w_hit_port;
    logic [PW-1:0]   w_addr_port;
    logic            w_ds_accept;
    logic            w_ds_ready;
    logic [1:0]      w_ds_resp;

    // A region with an all-zero mask is treated as disabled so unused upper ports never match.
    always_comb begin
        w_hit_port = DS_PORT;
        for (int i = NUM_MI - 1; i >= 0; i--) begin
            if ((((decode_addr_dec ^ REGION_BASE[i*22 +: 22]) & REGION_MASK[i*22 +: 22]) == 22'd0)
                && (REGION_MASK[i*22 +: 22] != 22'd0)) begin
                w_hit_port = PW'(i);
            end
        end
    end

    assign w_addr_port = ((trans_dec == 2'b00) && (r_data_port != DS_PORT)) ? r_data_port : w_hit_port;

    always_comb begin
        sel_out    = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_MI; i++) begin
            if (w_addr_port == PW'(i)) begin
                sel_out[i] = sel_dec;
                active_dec = active_in[i];
            end
        end
    end

    always_comb begin
        HREADYOUTS = w_ds_ready;
        HRESPS     = w_ds_resp;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int i = 0; i < NUM_MI; i++) begin
            if (r_data_port == PW'(i)) begin
                HREADYOUTS = readyout_in[i];
                HRESPS     = resp_in[2*i +: 2];
                HRDATAS    = rdata_in[32*i +: 32];
                HRUSERS    = ruser_in[USER_W*i +: USER_W];
            end
        end
    end

    assign w_ds_accept = sel_dec & HREADYS & trans_dec[1] & (w_addr_port == DS_PORT);

    always_comb begin
        w_state_nxt = r_state;
        w_ds_ready  = 1'b1;
        w_ds_resp   = 2'b00;
        case (r_state)
            DS_IDLE: begin
                if (w_ds_accept) w_state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                w_ds_ready  = 1'b0;
                w_ds_resp   = 2'b01;
                w_state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                w_ds_resp   = 2'b01;
                w_state_nxt = w_ds_accept ? DS_ERR1 : DS_IDLE;
            end
            default: w_state_nxt = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= DS_IDLE;
            r_data_port <= DS_PORT;
        end else begin
            r_state <= w_state_nxt;
            if (HREADYS) r_data_port <= w_addr_port;
        end
    end

`ifdef AHB_BM_DECODE_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;
    logic             w_err_inc;

    assign w_err_inc = (w_state_nxt == DS_ERR1) && (r_state != DS_ERR1);

    // Clear takes priority over a coincident increment; the count saturates at all-ones.
    always_ff @(posedge HCLK) begin
        if (HRESET || cnt_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_inc && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cmsdk_ahb_bm_decode_param.sv
// Directed bench for cmsdk_ahb_bm_decode_param: default 3-port build plus 1-port and 8-port
// overlapping-region instances checked for decode priority.
module tb_cmsdk_ahb_bm_decode_param;

`ifdef AHB_BM_DECODE_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HREADYS;
    logic        sel_dec;
    logic [21:0] decode_addr_dec;
    logic [1:0]  trans_dec;
    logic [2:0]  active_in;
    logic [2:0]  readyout_in;
    logic [5:0]  resp_in;
    logic [95:0] rdata_in;
    logic [95:0] ruser_in;
    logic        cnt_clr;
    logic [2:0]  sel_out;
    logic        active_dec;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic [31:0] HRDATAS;
    logic [31:0] HRUSERS;
    logic [7:0]  err_cnt;

    always #5 HCLK = ~HCLK;

    cmsdk_ahb_bm_decode_param u_dut (
        .HCLK(HCLK), .HRESET(HRESET), .HREADYS(HREADYS), .sel_dec(sel_dec),
        .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .active_in(active_in),
        .readyout_in(readyout_in), .resp_in(resp_in), .rdata_in(rdata_in), .ruser_in(ruser_in),
        .cnt_clr(cnt_clr), .sel_out(sel_out), .active_dec(active_dec), .HREADYOUTS(HREADYOUTS),
        .HRESPS(HRESPS), .HRDATAS(HRDATAS), .HRUSERS(HRUSERS), .err_cnt(err_cnt)
    );

    // Single-port instance with default regions
    logic [21:0] addr1;
    logic        active_in1;
    logic        sel_out1;
    logic        active_dec1;
    logic        ready1;
    logic [1:0]  resp1;
    logic [31:0] rdata1;
    logic [31:0] ruser1;
    logic [7:0]  cnt1;

    cmsdk_ahb_bm_decode_param #(.NUM_MI(1)) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .HREADYS(1'b0), .sel_dec(1'b1),
        .decode_addr_dec(addr1), .trans_dec(2'b10), .active_in(active_in1),
        .readyout_in(1'b1), .resp_in(2'b00), .rdata_in(32'h0), .ruser_in(32'h0),
        .cnt_clr(1'b0), .sel_out(sel_out1), .active_dec(active_dec1), .HREADYOUTS(ready1),
        .HRESPS(resp1), .HRDATAS(rdata1), .HRUSERS(ruser1), .err_cnt(cnt1)
    );

    // Eight-port instance with deliberately overlapping regions
    logic [21:0] addr8;
    logic [7:0]  sel_out8;
    logic        active_dec8;
    logic        ready8;
    logic [1:0]  resp8;
    logic [31:0] rdata8;
    logic [31:0] ruser8;
    logic [7:0]  cnt8;

    cmsdk_ahb_bm_decode_param #(
        .NUM_MI(8),
        .REGION_BASE({22'h3FFFFF, 22'h300000, 22'h200000, 22'h000000,
                      22'h100000, 22'h100000, 22'h120000, 22'h3FFFFF}),
        .REGION_MASK({22'h3FFFFF, 22'h300000, 22'h200000, 22'h200000,
                      22'h3C0000, 22'h300000, 22'h3E0000, 22'h3FFFFF})
    ) u_dut8 (
        .HCLK(HCLK), .HRESET(HRESET), .HREADYS(1'b0), .sel_dec(1'b1),
        .decode_addr_dec(addr8), .trans_dec(2'b10), .active_in(8'hFF),
        .readyout_in(8'hFF), .resp_in(16'h0), .rdata_in(256'h0), .ruser_in(256'h0),
        .cnt_clr(1'b0), .sel_out(sel_out8), .active_dec(active_dec8), .HREADYOUTS(ready8),
        .HRESPS(resp8), .HRDATAS(rdata8), .HRUSERS(ruser8), .err_cnt(cnt8)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
        #1;
        n_cmp++; if (HREADYOUTS !== 1'b1) begin n_mis++; $display("FAIL reset_ready: got %b want 1", HREADYOUTS); end
        n_cmp++; if (HRESPS !== 2'b00) begin n_mis++; $display("FAIL reset_resp: got %b want 00", HRESPS); end
        n_cmp++; if (HRDATAS !== 32'h0) begin n_mis++; $display("FAIL reset_rdata: got %h want 0", HRDATAS); end
        n_cmp++; if (HRUSERS !== 32'h0) begin n_mis++; $display("FAIL reset_ruser: got %h want 0", HRUSERS); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_mis++; $display("FAIL reset_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (sel_out !== 3'b000) begin n_mis++; $display("FAIL reset_sel: got %b want 000", sel_out); end
    endtask

    task automatic test_decode();
        decode_addr_dec = 22'h100004;
        trans_dec = 2'b10; sel_dec = 1'b1; HREADYS = 1'b1;
        #1;
        n_cmp++; if (sel_out !== 3'b010) begin n_mis++; $display("FAIL decode_sel: got %b want 010", sel_out); end
        n_cmp++; if (active_dec !== 1'b0) begin n_mis++; $display("FAIL decode_active: got %b want 0", active_dec); end
        tick();
        trans_dec = 2'b00; sel_dec = 1'b0;
        #1;
        n_cmp++; if (HRDATAS !== 32'h1111_1111) begin n_mis++; $display("FAIL decode_rdata: got %h want 11111111", HRDATAS); end
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_mis++; $display("FAIL decode_ready: got %b want 0", HREADYOUTS); end
        n_cmp++; if (HRESPS !== 2'b01) begin n_mis++; $display("FAIL decode_resp: got %b want 01", HRESPS); end
        n_cmp++; if (HRUSERS !== 32'hC1) begin n_mis++; $display("FAIL decode_ruser: got %h want c1", HRUSERS); end
    endtask

    task automatic test_unmapped();
        decode_addr_dec = 22'h300000;
        trans_dec = 2'b10; sel_dec = 1'b1; HREADYS = 1'b1;
        #1;
        n_cmp++; if (sel_out !== 3'b000) begin n_mis++; $display("FAIL unmap_sel: got %b want 000", sel_out); end
        n_cmp++; if (active_dec !== 1'b1) begin n_mis++; $display("FAIL unmap_active: got %b want 1", active_dec); end
        tick();
        n_cmp++; if ({HREADYOUTS, HRESPS} !== 3'b0_01) begin n_mis++; $display("FAIL unmap_err1: got %b want 001", {HREADYOUTS, HRESPS}); end
        n_cmp++; if (HRDATAS !== 32'h0) begin n_mis++; $display("FAIL unmap_rdata: got %h want 0", HRDATAS); end
        HREADYS = 1'b0; trans_dec = 2'b00; sel_dec = 1'b0;
        tick();
        n_cmp++; if ({HREADYOUTS, HRESPS} !== 3'b1_01) begin n_mis++; $display("FAIL unmap_err2: got %b want 101", {HREADYOUTS, HRESPS}); end
        n_cmp++; if (err_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin n_mis++; $display("FAIL unmap_cnt: got %0d want %0d", err_cnt, CNT_EN ? 1 : 0); end
        HREADYS = 1'b1;
        tick();
        n_cmp++; if ({HREADYOUTS, HRESPS} !== 3'b1_00) begin n_mis++; $display("FAIL unmap_done: got %b want 100", {HREADYOUTS, HRESPS}); end
    endtask

    task automatic test_default_okay();
        decode_addr_dec = 22'h300000;
        trans_dec = 2'b01; sel_dec = 1'b1; HREADYS = 1'b1;
        tick();
        n_cmp++; if ({HREADYOUTS, HRESPS} !== 3'b1_00) begin n_mis++; $display("FAIL busy_okay: got %b want 100", {HREADYOUTS, HRESPS}); end
        trans_dec = 2'b00;
        tick();
        n_cmp++; if ({HREADYOUTS, HRESPS} !== 3'b1_00) begin n_mis++; $display("FAIL idle_okay: got %b want 100", {HREADYOUTS, HRESPS}); end
        n_cmp++; if (err_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin n_mis++; $display("FAIL okay_cnt: got %0d want %0d", err_cnt, CNT_EN ? 1 : 0); end
        sel_dec = 1'b0;
    endtask

    task automatic test_idle_hold();
        decode_addr_dec = 22'h200000;
        trans_dec = 2'b10; sel_dec = 1'b1; HREADYS = 1'b1;
        #1;
        n_cmp++; if (sel_out !== 3'b100) begin n_mis++; $display("FAIL hold_sel_mi2: got %b want 100", sel_out); end
        tick();
        n_cmp++; if (HRDATAS !== 32'h2222_2222) begin n_mis++; $display("FAIL hold_rdata_a: got %h want 22222222", HRDATAS); end
        decode_addr_dec = 22'h3C0000;
        trans_dec = 2'b00;
        #1;
        n_cmp++; if (sel_out !== 3'b100) begin n_mis++; $display("FAIL hold_sel_idle: got %b want 100", sel_out); end
        n_cmp++; if (active_dec !== 1'b1) begin n_mis++; $display("FAIL hold_active: got %b want 1", active_dec); end
        tick();
        n_cmp++; if (HRDATAS !== 32'h2222_2222) begin n_mis++; $display("FAIL hold_rdata_b: got %h want 22222222", HRDATAS); end
        n_cmp++; if (HRUSERS !== 32'hC2) begin n_mis++; $display("FAIL hold_ruser: got %h want c2", HRUSERS); end
        sel_dec = 1'b0;
    endtask

    task automatic test_mid_error_reset();
        decode_addr_dec = 22'h300000;
        trans_dec = 2'b10; sel_dec = 1'b1; HREADYS = 1'b1;
        tick();
        n_cmp++; if (HREADYOUTS !== 1'b0) begin n_mis++; $display("FAIL mrst_err1: got %b want 0", HREADYOUTS); end
        HRESET = 1'b1; HREADYS = 1'b0; trans_dec = 2'b00; sel_dec = 1'b0;
        tick();
        HRESET = 1'b0; HREADYS = 1'b1;
        #1;
        n_cmp++; if ({HREADYOUTS, HRESPS} !== 3'b1_00) begin n_mis++; $display("FAIL mrst_resp: got %b want 100", {HREADYOUTS, HRESPS}); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_mis++; $display("FAIL mrst_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (HRDATAS !== 32'h0) begin n_mis++; $display("FAIL mrst_rdata: got %h want 0", HRDATAS); end
    endtask

    task automatic do_error(input logic clr);
        decode_addr_dec = 22'h300000;
        sel_dec = 1'b1; trans_dec = 2'b10; HREADYS = 1'b1; cnt_clr = clr;
        tick();
        sel_dec = 1'b0; trans_dec = 2'b00; HREADYS = 1'b0; cnt_clr = 1'b0;
        tick();
    endtask

    task automatic test_counter();
        for (int k = 0; k < 255; k++) do_error(1'b0);
        n_cmp++; if (err_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin n_mis++; $display("FAIL cnt_255: got %0d want %0d", err_cnt, CNT_EN ? 255 : 0); end
        do_error(1'b0);
        n_cmp++; if (err_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin n_mis++; $display("FAIL cnt_sat: got %0d want %0d", err_cnt, CNT_EN ? 255 : 0); end
        do_error(1'b1);
        n_cmp++; if (err_cnt !== 8'd0) begin n_mis++; $display("FAIL cnt_clr_wins: got %0d want 0", err_cnt); end
        do_error(1'b0);
        n_cmp++; if (err_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin n_mis++; $display("FAIL cnt_resume: got %0d want %0d", err_cnt, CNT_EN ? 1 : 0); end
        HREADYS = 1'b1;
        tick();
    endtask

    task automatic test_param_variants();
        logic [21:0] a8 [5];
        logic [7:0]  e8 [5];
        a8[0] = 22'h120000; e8[0] = 8'b0000_0010;
        a8[1] = 22'h100000; e8[1] = 8'b0000_0100;
        a8[2] = 22'h040000; e8[2] = 8'b0001_0000;
        a8[3] = 22'h300000; e8[3] = 8'b0010_0000;
        a8[4] = 22'h3FFFFF; e8[4] = 8'b0000_0001;
        for (int k = 0; k < 5; k++) begin
            addr8 = a8[k];
            #1;
            n_cmp++; if (sel_out8 !== e8[k]) begin n_mis++; $display("FAIL mi8_sel[%0d]: got %b want %b", k, sel_out8, e8[k]); end
        end
        active_in1 = 1'b0;
        addr1 = 22'h000004;
        #1;
        n_cmp++; if (sel_out1 !== 1'b1) begin n_mis++; $display("FAIL mi1_sel_hit: got %b want 1", sel_out1); end
        n_cmp++; if (active_dec1 !== 1'b0) begin n_mis++; $display("FAIL mi1_active_hit: got %b want 0", active_dec1); end
        addr1 = 22'h100000;
        #1;
        n_cmp++; if (sel_out1 !== 1'b0) begin n_mis++; $display("FAIL mi1_sel_miss: got %b want 0", sel_out1); end
        n_cmp++; if (active_dec1 !== 1'b1) begin n_mis++; $display("FAIL mi1_active_miss: got %b want 1", active_dec1); end
    endtask

    initial begin
        HRESET = 1'b0; HREADYS = 1'b1; sel_dec = 1'b0; trans_dec = 2'b00;
        decode_addr_dec = 22'h0; cnt_clr = 1'b0;
        active_in   = 3'b101;
        readyout_in = 3'b101;
        resp_in     = 6'b00_01_00;
        rdata_in    = {32'h2222_2222, 32'h1111_1111, 32'h0000_0F0F};
        ruser_in    = {32'hC2, 32'hC1, 32'hC0};
        addr1 = 22'h0; addr8 = 22'h0; active_in1 = 1'b1;

        test_reset();
        test_decode();
        test_unmapped();
        test_default_okay();
        test_idle_hold();
        test_mid_error_reset();
        test_reset();
        test_counter();
        test_param_variants();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
